qpu_measure_collector: RTL and testbench

Measurement collection stage that sits directly upstream of the execution-unit register file's measurement-result registers. It accepts a measurement batch from the dispatch/OITF side as a qubit list, then gathers per-qubit readout results from the readout electronics as they arrive out of order. Once every listed qubit has reported, or a timeout expires, it issues a single-cycle write pulse carrying the result vector and the measure list. That pulse drives the regfile's `mcu_measure_i_wen` / `mcu_measure_i_data` / `oitf_ret_i_measurelist` inputs.

---
 rtl/qpu_measure_collector.sv | 135 +++++++++++++
 tb/tb_qpu_measure_collector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_measure_collector.sv
// Measurement collection stage: latches a qubit batch list, gathers out-of-order
// readout results, and emits one commit pulse toward the regfile on completion or timeout.
module qpu_measure_collector #(
    parameter int QUBIT_NUM      = 12,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 meas_req_valid,
    output logic                 meas_req_ready,
    input  logic [QUBIT_NUM-1:0] meas_req_list,
    input  logic [QUBIT_NUM-1:0] rd_valid,
    input  logic [QUBIT_NUM-1:0] rd_data,
    output logic                 mcu_measure_o_wen,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 mcu_timeout,
    output logic                 mcu_busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [QUBIT_NUM-1:0] r_list;
    logic [QUBIT_NUM-1:0] r_pend;
    logic [QUBIT_NUM-1:0] r_data;
    logic [QUBIT_NUM-1:0] r_outData;
    logic [QUBIT_NUM-1:0] r_outList;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_to;

    logic [QUBIT_NUM-1:0] w_capture;
    logic [QUBIT_NUM-1:0] w_dataNext;
    logic [QUBIT_NUM-1:0] w_pendNext;
    logic                 w_done;
    logic                 w_cntAtLimit;
    logic                 w_acceptBatch;

    // Only still-pending qubits take a strobe, so duplicates and off-list strobes fall away.
    assign w_capture     = rd_valid & r_pend;
    assign w_dataNext    = (r_data & ~w_capture) | (rd_data & w_capture);
    assign w_pendNext    = r_pend & ~rd_valid;
    assign w_done        = (w_pendNext == '0);
    assign w_cntAtLimit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_acceptBatch = meas_req_valid && (meas_req_list != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext       = r_state;
        meas_req_ready    = 1'b0;
        mcu_measure_o_wen = 1'b0;
        mcu_timeout       = 1'b0;
        mcu_busy          = 1'b1;
        case (r_state)
            IDLE: begin
                meas_req_ready = 1'b1;
                mcu_busy       = 1'b0;
                if (w_acceptBatch) begin
                    w_stateNext = COLLECT;
                end
            end
            COLLECT: begin
                if (w_done || w_cntAtLimit) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                mcu_measure_o_wen = 1'b1;
                mcu_timeout       = r_to;
                w_stateNext       = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Result/list outputs are separate so they keep the last commit while a new batch clears r_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_list    <= '0;
            r_pend    <= '0;
            r_data    <= '0;
            r_outData <= '0;
            r_outList <= '0;
            r_cnt     <= '0;
            r_to      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acceptBatch) begin
                        r_list <= meas_req_list;
                        r_pend <= meas_req_list;
                        r_data <= '0;
                        r_cnt  <= '0;
                        r_to   <= 1'b0;
                    end
                end
                COLLECT: begin
                    r_pend <= w_pendNext;
                    r_data <= w_dataNext;
                    if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_done || w_cntAtLimit) begin
                        r_to      <= !w_done;
                        r_outData <= w_dataNext;
                        r_outList <= r_list;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mcu_measure_o_data = r_outData;
    assign mcu_measure_o_list = r_outList;

endmodule

// File: tb/tb_qpu_measure_collector.sv
// Randomized self-checking bench for qpu_measure_collector: per-batch commit timing and
// contents are predicted from the strobe schedule and checked against the DUT every cycle.
module tb_qpu_measure_collector;

    localparam int QN = 12;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          meas_req_valid = 1'b0;
    logic          meas_req_ready;
    logic [QN-1:0] meas_req_list = '0;
    logic [QN-1:0] rd_valid = '0;
    logic [QN-1:0] rd_data = '0;
    logic          mcu_measure_o_wen;
    logic [QN-1:0] mcu_measure_o_data;
    logic [QN-1:0] mcu_measure_o_list;
    logic          mcu_timeout;
    logic          mcu_busy;

    qpu_measure_collector #(.QUBIT_NUM(QN), .TIMEOUT_CYCLES(T)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .meas_req_valid    (meas_req_valid),
        .meas_req_ready    (meas_req_ready),
        .meas_req_list     (meas_req_list),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .mcu_measure_o_wen (mcu_measure_o_wen),
        .mcu_measure_o_data(mcu_measure_o_data),
        .mcu_measure_o_list(mcu_measure_o_list),
        .mcu_timeout       (mcu_timeout),
        .mcu_busy          (mcu_busy)
    );

    always #5 clk = ~clk;

    int cycNum = 0;
    always @(posedge clk) cycNum <= cycNum + 1;

    int nCompared = 0;
    int nMismatch = 0;

    // Expected-behaviour state, written by the stimulus side per batch.
    int            acceptAt = -10;
    int            commitAt = -5;
    logic [QN-1:0] commitData = '0;
    logic [QN-1:0] commitList = '0;
    logic          commitTo = 1'b0;
    logic [QN-1:0] heldData = '0;
    logic [QN-1:0] heldList = '0;

    logic [QN-1:0] schedV [0:T+1];
    logic [QN-1:0] schedD [0:T+1];

    int            wenCount = 0;
    int            lastWenCycle = 0;
    logic [QN-1:0] lastWenData = '0;
    logic          lastWenTo = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycNum, actual, expected);
        end
    endtask

    // Every-cycle comparison against the batch-level expectations.
    always @(negedge clk) begin
        int  c;
        bit  busyE;
        bit  wenE;
        c     = cycNum;
        busyE = (c > acceptAt) && (c <= commitAt);
        wenE  = (c == commitAt);
        checkOutput("ready", 32'(meas_req_ready), 32'(!busyE));
        checkOutput("busy", 32'(mcu_busy), 32'(busyE));
        checkOutput("wen", 32'(mcu_measure_o_wen), 32'(wenE));
        checkOutput("timeout", 32'(mcu_timeout), 32'(wenE && commitTo));
        checkOutput("data", 32'(mcu_measure_o_data), 32'((c >= commitAt) ? commitData : heldData));
        checkOutput("list", 32'(mcu_measure_o_list), 32'((c >= commitAt) ? commitList : heldList));
        if (mcu_measure_o_wen === 1'b1) begin
            wenCount++;
            lastWenCycle = c;
            lastWenData  = mcu_measure_o_data;
            lastWenTo    = mcu_timeout;
        end
    end

    task automatic clearSched();
        for (int t = 0; t <= T + 1; t++) begin
            schedV[t] = '0;
            schedD[t] = '0;
        end
    endtask

    // Drive one batch (accept offset 0, strobes at offsets 0..T+1) after predicting its commit.
    task automatic applyStimulus(input logic [QN-1:0] list, output int acceptCyc);
        logic [QN-1:0] got;
        logic [QN-1:0] dat;
        int            last;
        int            commitOff;
        got = '0;
        dat = '0;
        last = 0;
        commitOff = T;
        for (int t = 1; t <= T; t++) begin
            for (int k = 0; k < QN; k++) begin
                if (list[k] && !got[k] && schedV[t][k]) begin
                    got[k] = 1'b1;
                    dat[k] = schedD[t][k];
                    last   = t;
                end
            end
        end
        @(posedge clk);
        #1;
        acceptCyc = cycNum;
        if (list != '0) begin
            commitOff  = (got == list) ? last : T;
            heldData   = commitData;
            heldList   = commitList;
            commitData = dat;
            commitList = list;
            commitTo   = (got != list);
            acceptAt   = acceptCyc;
            commitAt   = acceptCyc + commitOff + 1;
        end
        meas_req_valid = 1'b1;
        meas_req_list  = list;
        rd_valid       = schedV[0];
        rd_data        = schedD[0];
        for (int t = 1; t <= T + 1; t++) begin
            @(posedge clk);
            #1;
            rd_valid = schedV[t];
            rd_data  = schedD[t];
            if (list != '0 && t <= commitOff + 1) begin
                meas_req_valid = 1'($urandom);
                meas_req_list  = QN'($urandom);
            end else begin
                meas_req_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        meas_req_valid = 1'b0;
        meas_req_list  = '0;
        rd_valid       = '0;
        rd_data        = '0;
    endtask

    initial begin
        int a;
        int w0;
        clearSched();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(meas_req_ready), 32'd1);
        checkOutput("rst_data", 32'(mcu_measure_o_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_busy", 32'(mcu_busy), 32'd0);
        checkOutput("rel_list", 32'(mcu_measure_o_list), 32'd0);

        // In-order batch.
        clearSched();
        schedV[1] = 12'h001; schedD[1] = 12'h001;
        schedV[3] = 12'h004; schedD[3] = 12'h000;
        w0 = wenCount;
        applyStimulus(12'h005, a);
        checkOutput("inorder_lat", 32'(lastWenCycle - a), 32'd4);
        checkOutput("inorder_data", 32'(lastWenData), 32'h001);
        checkOutput("inorder_to", 32'(lastWenTo), 32'd0);
        checkOutput("inorder_cnt", 32'(wenCount - w0), 32'd1);

        // All results in the first collect cycle.
        clearSched();
        schedV[1] = 12'hFFF; schedD[1] = 12'hA5A;
        applyStimulus(12'hFFF, a);
        checkOutput("full_lat", 32'(lastWenCycle - a), 32'd2);
        checkOutput("full_data", 32'(lastWenData), 32'hA5A);

        // Spurious and duplicate strobes.
        clearSched();
        schedV[1] = 12'h001; schedD[1] = 12'h001;
        schedV[2] = 12'h002; schedD[2] = 12'h002;
        schedV[3] = 12'h002; schedD[3] = 12'h000;
        w0 = wenCount;
        applyStimulus(12'h002, a);
        checkOutput("dup_lat", 32'(lastWenCycle - a), 32'd3);
        checkOutput("dup_data", 32'(lastWenData), 32'h002);
        checkOutput("dup_cnt", 32'(wenCount - w0), 32'd1);

        // Timeout with qubit 1 missing.
        clearSched();
        schedV[1] = 12'h001; schedD[1] = 12'h001;
        applyStimulus(12'h003, a);
        checkOutput("to_lat", 32'(lastWenCycle - a), 32'd9);
        checkOutput("to_data", 32'(lastWenData), 32'h001);
        checkOutput("to_flag", 32'(lastWenTo), 32'd1);

        // Last result on the final counter value: completion wins.
        clearSched();
        schedV[2] = 12'h001; schedD[2] = 12'h001;
        schedV[8] = 12'h002; schedD[8] = 12'h002;
        applyStimulus(12'h003, a);
        checkOutput("edge_lat", 32'(lastWenCycle - a), 32'd9);
        checkOutput("edge_data", 32'(lastWenData), 32'h003);
        checkOutput("edge_flag", 32'(lastWenTo), 32'd0);

        // Strobe in the accept cycle is not captured.
        clearSched();
        schedV[0] = 12'hFFF; schedD[0] = 12'hFFF;
        schedV[2] = 12'h001; schedD[2] = 12'h000;
        applyStimulus(12'h001, a);
        checkOutput("acc_data", 32'(lastWenData), 32'h000);

        // Zero list is accepted without a commit.
        clearSched();
        schedV[1] = 12'hFFF; schedD[1] = 12'hFFF;
        w0 = wenCount;
        applyStimulus(12'h000, a);
        checkOutput("zero_cnt", 32'(wenCount - w0), 32'd0);

        // Reset in the middle of collection aborts the batch.
        w0 = wenCount;
        @(posedge clk);
        #1;
        heldData = commitData;
        heldList = commitList;
        acceptAt = cycNum;
        commitAt = 32'h3fff_ffff;
        meas_req_valid = 1'b1;
        meas_req_list  = 12'h00F;
        @(posedge clk);
        #1;
        meas_req_valid = 1'b0;
        rd_valid = 12'h001; rd_data = 12'h001;
        @(posedge clk);
        #1;
        rd_valid = 12'h002; rd_data = 12'h002;
        @(posedge clk);
        #1;
        rd_valid = '0; rd_data = '0;
        acceptAt = -10; commitAt = -5;
        commitData = '0; commitList = '0; commitTo = 1'b0;
        heldData = '0; heldList = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_cnt", 32'(wenCount - w0), 32'd0);
        checkOutput("abort_ready", 32'(meas_req_ready), 32'd1);
        clearSched();
        schedV[1] = 12'h00F; schedD[1] = 12'h009;
        applyStimulus(12'h00F, a);
        checkOutput("post_data", 32'(lastWenData), 32'h009);
        checkOutput("post_lat", 32'(lastWenCycle - a), 32'd2);

        // Randomized batches with varying strobe density.
        for (int b = 0; b < 60; b++) begin
            logic [QN-1:0] lst;
            int dens;
            dens = $urandom_range(0, 2);
            for (int t = 0; t <= T + 1; t++) begin
                schedV[t] = QN'($urandom);
                if (dens >= 1) schedV[t] = schedV[t] & QN'($urandom);
                if (dens >= 2) schedV[t] = schedV[t] & QN'($urandom);
                schedD[t] = QN'($urandom);
            end
            lst = QN'($urandom);
            if ($urandom_range(0, 3) == 0) lst = lst & QN'($urandom) & QN'($urandom);
            if ($urandom_range(0, 15) == 0) lst = '0;
            applyStimulus(lst, a);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
